// File: rtl/bin_2_bcd_seq.sv
// rtl/bin_2_bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter
//
// Converts an unsigned BIN_WIDTH-bit value into BCD_WIDTH decimal digits,
// one input bit per clock, with a valid/ready request handshake, saturating
// overflow and per-digit leading-zero blank flags.
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   bin_i       binary value, sampled when valid_i && ready_o
//   valid_i     conversion request
//   ready_o     converter idle, request will be accepted
//   bcd_o       result digits, index 0 = least significant
//   blank_o     per-digit leading-zero blank flag (bit 0 always 0)
//   overflow_o  value exceeded 10^BCD_WIDTH-1 (result saturated to all 9s)
//   valid_o     one-cycle pulse, result outputs updated

module bin_2_bcd_seq #(
    parameter int BIN_WIDTH = 16,
    parameter int BCD_WIDTH = 5,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [BIN_WIDTH-1:0]       bin_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [BCD_WIDTH-1:0][3:0]  bcd_o,
    output logic [BCD_WIDTH-1:0]       blank_o,
    output logic                       overflow_o,
    output logic                       valid_o
);

    // A 1-bit counter is kept even for BIN_WIDTH = 1 so the register exists.
    localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic [BIN_WIDTH-1:0]        shift_q;
    logic [BCD_WIDTH-1:0][3:0]   work_q;
    logic [BCD_WIDTH-1:0][3:0]   work_adj;
    logic [BCD_WIDTH-1:0][3:0]   work_d;
    logic                        top_bit_out;
    logic                        ovf_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [BCD_WIDTH-1:0]        blank_d;
    logic                        all_zero;

    assign ready_o = (state_q == IDLE);

    // Add-3 correction followed by the one-bit left shift of {work, shift}.
    // A digit >= 5 becomes >= 8 after correction, so its bit 3 is exactly the
    // decimal carry; out of the top digit that carry means the value no longer
    // fits in BCD_WIDTH digits.
    always_comb begin
        work_adj = work_q;
        for (int d = 0; d < BCD_WIDTH; d++) begin
            if (work_q[d] >= 4'd5) begin
                work_adj[d] = work_q[d] + 4'd3;
            end
        end
        {top_bit_out, work_d} = {work_adj, shift_q[BIN_WIDTH-1]};
    end

    // Digit d is blanked when it and every more significant digit are zero.
    // Digit 0 is never blanked so a zero value still shows a single "0".
    always_comb begin
        blank_d  = '0;
        all_zero = 1'b1;
        for (int d = BCD_WIDTH - 1; d >= 1; d--) begin
            all_zero   = all_zero && (work_q[d] == 4'd0);
            blank_d[d] = all_zero;
        end
        if (!BLANK_LZ || ovf_q) begin
            blank_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q    <= '0;
            work_q     <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            bcd_o      <= '0;
            blank_o    <= '0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        shift_q <= bin_i;
                        work_q  <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= CNT_W'(BIN_WIDTH - 1);
                    end
                end
                SHIFT: begin
                    work_q  <= work_d;
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (top_bit_out) begin
                        ovf_q <= 1'b1;
                    end
                end
                FINISH: begin
                    valid_o    <= 1'b1;
                    overflow_o <= ovf_q;
                    blank_o    <= blank_d;
                    bcd_o      <= ovf_q ? {BCD_WIDTH{4'd9}} : work_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_2_bcd_seq.sv
// tb/tb_bin_2_bcd_seq.sv - self-checking bench for bin_2_bcd_seq

module tb_bin_2_bcd_seq;

    typedef struct {
        int          inst;
        logic [19:0] bcd;
        logic [4:0]  blank;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   vcnt[3];
    int   vlast[3];

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // inst 0: defaults, inst 1: BCD_WIDTH = 4, inst 2: BLANK_LZ = 0
    logic             rst0, rst1, rst2;
    logic [15:0]      bin0, bin1, bin2;
    logic             vi0, vi1, vi2;
    logic             rdy0, rdy1, rdy2;
    logic [4:0][3:0]  bcd0, bcd2;
    logic [3:0][3:0]  bcd1;
    logic [4:0]       blank0, blank2;
    logic [3:0]       blank1;
    logic             ovf0, ovf1, ovf2;
    logic             vo0, vo1, vo2;

    bin_2_bcd_seq u_dut0 (
        .clk_i(clk), .rst_i(rst0), .bin_i(bin0), .valid_i(vi0), .ready_o(rdy0),
        .bcd_o(bcd0), .blank_o(blank0), .overflow_o(ovf0), .valid_o(vo0)
    );

    bin_2_bcd_seq #(.BIN_WIDTH(16), .BCD_WIDTH(4), .BLANK_LZ(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .bin_i(bin1), .valid_i(vi1), .ready_o(rdy1),
        .bcd_o(bcd1), .blank_o(blank1), .overflow_o(ovf1), .valid_o(vo1)
    );

    bin_2_bcd_seq #(.BIN_WIDTH(16), .BCD_WIDTH(5), .BLANK_LZ(1'b0)) u_dut2 (
        .clk_i(clk), .rst_i(rst2), .bin_i(bin2), .valid_i(vi2), .ready_o(rdy2),
        .bcd_o(bcd2), .blank_o(blank2), .overflow_o(ovf2), .valid_o(vo2)
    );

    // Reference built from decimal division, independent of shift-and-add-3.
    function automatic exp_t model(int inst, int unsigned v);
        exp_t        e;
        int          nd;
        int unsigned lim, t, p;
        nd  = (inst == 1) ? 4 : 5;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        e.inst  = inst;
        e.ovf   = (v >= lim);
        e.bcd   = '0;
        e.blank = '0;
        t = v;
        p = 1;
        for (int d = 0; d < nd; d++) begin
            e.bcd[d*4 +: 4] = e.ovf ? 4'd9 : 4'(t % 10);
            t = t / 10;
            if (d >= 1 && inst != 2 && !e.ovf && v < p) e.blank[d] = 1'b1;
            p = p * 10;
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(int inst, logic [19:0] b, logic [4:0] bl, logic ov);
        exp_t e;
        chk("unexpected_valid", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("result_inst", inst, e.inst);
            chk("bcd", b, e.bcd);
            chk("blank", bl, e.blank);
            chk("overflow", ov, e.ovf);
        end
        vcnt[inst]++;
        vlast[inst] = cyc;
    endtask

    always @(negedge clk) begin
        if (vo0) check_out(0, bcd0, blank0, ovf0);
        if (vo1) check_out(1, {4'h0, bcd1}, {1'b0, blank1}, ovf1);
        if (vo2) check_out(2, bcd2, blank2, ovf2);
    end

    task automatic drive(int inst, logic [15:0] v, logic vld);
        case (inst)
            0: begin bin0 = v; vi0 = vld; end
            1: begin bin1 = v; vi1 = vld; end
            default: begin bin2 = v; vi2 = vld; end
        endcase
    endtask

    task automatic start(int inst, logic [15:0] v, bit push);
        @(negedge clk); #1;
        drive(inst, v, 1'b1);
        if (push) sb.push_back(model(inst, v));
        @(posedge clk); #1;
        drive(inst, v, 1'b0);
    endtask

    task automatic wait_valid(int inst, int n0, string tag);
        for (int k = 0; k < 200 && vcnt[inst] == n0; k++) begin
            @(negedge clk); #1;
        end
        chk({tag, "_timeout"}, (vcnt[inst] != n0), 1);
    endtask

    task automatic convert(int inst, logic [15:0] v, string tag);
        int n0;
        n0 = vcnt[inst];
        start(inst, v, 1'b1);
        wait_valid(inst, n0, tag);
    endtask

    initial begin
        int   n0, t_drv, t1, low;
        exp_t e;
        for (int i = 0; i < 3; i++) begin vcnt[i] = 0; vlast[i] = 0; end
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        bin0 = '0; bin1 = '0; bin2 = '0;
        vi0 = 1'b0; vi1 = 1'b0; vi2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_ready", rdy0, 1);
        chk("reset_valid", vo0, 0);
        chk("reset_bcd", bcd0, 0);
        chk("reset_blank", blank0, 0);
        chk("reset_overflow", ovf0, 0);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        // 12345: ready low 17 cycles, valid 17 cycles after acceptance
        @(negedge clk); #1;
        t_drv = cyc;
        n0    = vcnt[0];
        drive(0, 16'd12345, 1'b1);
        sb.push_back(model(0, 12345));
        @(posedge clk); #1;
        drive(0, 16'd12345, 1'b0);
        low = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (rdy0) break;
            low++;
        end
        chk("ready_low_cycles", low, 17);
        wait_valid(0, n0, "v12345");
        chk("latency", vlast[0] - (t_drv + 1), 17);

        // back-to-back 0 then 7 with valid_i held high
        @(negedge clk); #1;
        n0 = vcnt[0];
        drive(0, 16'd0, 1'b1);
        sb.push_back(model(0, 0));
        for (int k = 0; k < 100 && vcnt[0] == n0; k++) begin
            @(negedge clk); #1;
        end
        chk("b2b_first_timeout", (vcnt[0] != n0), 1);
        t1 = vlast[0];
        drive(0, 16'd7, 1'b1);
        sb.push_back(model(0, 7));
        @(posedge clk); #1;
        drive(0, 16'd7, 1'b0);
        n0 = vcnt[0];
        wait_valid(0, n0, "b2b_second");
        chk("b2b_spacing", vlast[0] - t1, 18);

        convert(0, 16'd65535, "v65535");

        // outputs hold during the next conversion
        n0 = vcnt[0];
        start(0, 16'd305, 1'b1);
        repeat (5) begin @(negedge clk); #1; end
        e = model(0, 65535);
        chk("hold_bcd", bcd0, e.bcd);
        chk("hold_ready", rdy0, 0);
        chk("hold_valid", vo0, 0);
        wait_valid(0, n0, "v305");

        convert(1, 16'd9999, "w4_9999");
        convert(1, 16'd10000, "w4_10000");
        convert(1, 16'd12345, "w4_12345");

        // asynchronous reset five cycles into a conversion of 4321
        start(0, 16'd4321, 1'b0);
        repeat (4) @(posedge clk);
        @(posedge clk); #2;
        rst0 = 1'b1;
        #1;
        chk("abort_ready", rdy0, 1);
        chk("abort_bcd", bcd0, 0);
        chk("abort_blank", blank0, 0);
        chk("abort_valid", vo0, 0);
        @(negedge clk); #1;
        rst0 = 1'b0;
        n0 = vcnt[0];
        repeat (30) begin @(negedge clk); #1; end
        chk("abort_no_valid", vcnt[0], n0);
        convert(0, 16'd42, "v42");

        // BLANK_LZ = 0, request during SHIFT is ignored
        n0 = vcnt[2];
        start(2, 16'd9, 1'b1);
        repeat (3) begin @(negedge clk); #1; end
        drive(2, 16'd1234, 1'b1);
        repeat (3) begin @(negedge clk); #1; end
        drive(2, 16'd1234, 1'b0);
        wait_valid(2, n0, "nolz_9");
        repeat (30) begin @(negedge clk); #1; end
        chk("nolz_single_result", vcnt[2], n0 + 1);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bin_2_bcd_seq.md
Name: bin_2_bcd_seq

Overview:
- Multi-cycle, parametrised binary-to-BCD converter using iterative shift-and-add-3, one input bit per clock.
- Successor to the combinational converter. It is for wide score/line counters where an unrolled converter is too deep for timing.
- Adds:
  - valid/ready handshake,
  - overflow detection with saturation,
  - per-digit leading-zero blanking flags for the seven-segment/score display path.

Parameters:
- BIN_WIDTH, 16, width of the binary input (≥1).
- BCD_WIDTH, 5, number of BCD output digits (≥1).
- BLANK_LZ, 1, 1 = generate leading-zero blank flags; 0 = blank_o tied to all zeros.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- bin_i  in  BIN_WIDTH  unsigned binary value, sampled on acceptance.
- valid_i  in  1  input request.
- ready_o  out  1  converter idle and able to accept.
- bcd_o  out  [BCD_WIDTH-1:0][3:0]  result digits; index 0 = least significant.
- blank_o  out  BCD_WIDTH  per-digit leading-zero blank flag.
- overflow_o  out  1  value exceeded 10^BCD_WIDTH-1; qualified by valid_o.
- valid_o  out  1  one-cycle pulse: bcd_o/blank_o/overflow_o updated.

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-high on rst_i.
- Reset values:
  - state = IDLE, ready_o = 1, valid_o = 0,
  - bcd_o = 0, blank_o = 0, overflow_o = 0,
  - internal shift, work and counter registers = 0.
- FSM states: IDLE, SHIFT, FINISH. ready_o = (state == IDLE), decoded from the state register.
- IDLE:
  - Acceptance happens on the edge where valid_i && ready_o.
  - On acceptance: capture bin_i into the shift register, clear the BCD work register and the overflow sticky bit, load bit counter = BIN_WIDTH-1, go to SHIFT.
  - valid_i while not ready_o is ignored. No queuing; the requester holds valid_i until accepted.
- SHIFT (one step per cycle):
  - Every work digit ≥5 gets +3, 4-bit wrap-free.
  - Then shift {work, shift reg} left by 1, MSB of bin first.
  - If the bit shifted out of digit BCD_WIDTH-1 bit 3 is 1, set the overflow sticky bit.
  - Counter decrements. On the step where counter == 0, go to FINISH.
  - SHIFT lasts exactly BIN_WIDTH cycles.
- FINISH (single cycle): register the outputs and pulse valid_o for one cycle, then return to IDLE.
  - If overflow sticky is set: bcd_o = all digits 9, overflow_o = 1, blank_o = 0.
  - Otherwise: bcd_o = work register, overflow_o = 0.
  - blank_o[d] (d ≥ 1) = 1 when digits d..BCD_WIDTH-1 are all zero. blank_o[0] is always 0, so zero displays as a single "0". With BLANK_LZ = 0, blank_o = 0.
- Timing and hold:
  - Latency: acceptance edge to first cycle with valid_o = 1 is BIN_WIDTH+1 cycles.
  - ready_o returns to 1 in the same cycle valid_o is high, so back-to-back throughput is one conversion per BIN_WIDTH+2 cycles.
  - bcd_o, blank_o and overflow_o hold their last values until the next FINISH. They do not change during a later conversion.
- Arithmetic:
  - Work register is BCD_WIDTH×4 bits. No digit ever exceeds 9.
  - Without overflow, the result equals bin_i in decimal.
  - Overflow is detected for any BIN_WIDTH/BCD_WIDTH combination, including BCD_WIDTH too small for 2^BIN_WIDTH-1.
- Boundaries:
  - bin_i = 0 gives all digits 0, blank_o = all ones except bit 0.
  - bin_i = 10^BCD_WIDTH-1 gives no overflow.
  - bin_i = 10^BCD_WIDTH gives overflow.
  - BIN_WIDTH = 1 still passes through SHIFT for exactly 1 cycle.
- Reset mid-conversion: the conversion is aborted immediately, all outputs take their reset values, and no valid_o pulse is issued for the aborted value.
- bin_i changing after acceptance has no effect on the running conversion.

Test Plan:
- Defaults (16/5/1), bin_i=12345, valid_i pulse → ready_o low for 17 cycles; valid_o high exactly 17 cycles after the acceptance edge; bcd_o = {1,2,3,4,5}, blank_o = 0, overflow_o = 0.
- Defaults, bin_i=0 then bin_i=7 back-to-back, valid_i held high → first result {0,0,0,0,0} with blank_o = 5'b11110; second accepted in the valid_o cycle, result {0,0,0,0,7} with blank_o = 5'b11110; valid_o pulses 18 cycles apart.
- Defaults, bin_i=65535 → bcd_o = {6,5,5,3,5}, overflow_o = 0. Then bin_i=305 → {0,0,3,0,5}, blank_o = 5'b11000.
- BCD_WIDTH=4: bin_i=9999 → {9,9,9,9}, overflow_o = 0. bin_i=10000 → {9,9,9,9}, overflow_o = 1, blank_o = 0. bin_i=12345 → same saturated result with overflow.
- Defaults, assert rst_i asynchronously 5 cycles into a conversion of 4321 → ready_o = 1, bcd_o = 0, valid_o = 0 immediately; no valid_o pulse afterwards. A new request for 42 then completes normally with {0,0,0,4,2}.
- BLANK_LZ=0, bin_i=9 → bcd_o = {0,0,0,0,9}, blank_o = 0. valid_i asserted during SHIFT with a different bin_i → ignored; the result is unchanged.
